// File: rtl/div_unit_if.sv
// Request/response bundle between the datapath control and the sequential divider.
// master issues start with operands and watches busy/done; slave is the divider.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             div_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, div_signed, dividend, divisor,
      input  q, r, busy, done, div_zero
   );

   modport slave (
      input  start, div_signed, dividend, divisor,
      output q, r, busy, done, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: q/r valid 33 cycles after start, with a one-cycle done pulse.
// start is taken only while idle; requests and operand changes during busy are ignored.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dsor;
   logic [WIDTH-1:0] raw_dvd;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;
   logic             sign_r;
   logic             zero;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   // quo doubles as the dividend shifter: its MSB feeds acc while quotient bits enter at the LSB.
   // Since acc < dsor, the shifted value minus dsor always fits a 33-bit signed result.
   always_comb begin
      rem_sh = {acc, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, dsor};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         quo          <= '0;
         dsor         <= '0;
         raw_dvd      <= '0;
         cnt          <= '0;
         sign_q       <= 1'b0;
         sign_r       <= 1'b0;
         zero         <= 1'b0;
         bus.q        <= '0;
         bus.r        <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.div_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  quo      <= mag(bus.dividend, bus.div_signed);
                  dsor     <= mag(bus.divisor, bus.div_signed);
                  sign_q   <= bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                  sign_r   <= bus.div_signed & bus.dividend[WIDTH-1];
                  zero     <= (bus.divisor == '0);
                  raw_dvd  <= bus.dividend;
                  acc      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  acc <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (zero) begin
                  bus.q        <= '1;
                  bus.r        <= raw_dvd;
                  bus.div_zero <= 1'b1;
               end else begin
                  bus.q        <= sign_q ? -quo : quo;
                  bus.r        <= sign_r ? -acc : acc;
                  bus.div_zero <= 1'b0;
               end
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
